trap_ctrl: RTL
==============

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 clk_i  input  1  the single block clock; all state updates on its rising edge.
REQ-002 rst_i  input  1  reset, asynchronous and active-high; forces every register to its reset value immediately.
REQ-003 exception_i  input  32  exception flags from exe, decoded as bit0 ecall, bit1 ebreak, bit2 illegal, bit3 mret; other bits ignored.
REQ-004 inst_addr_i  input  32  PC of the instruction currently in exe.
REQ-005 jump_enable_i, jump_addr_i  input  1/32  branch/jump resolved in exe this cycle, and its target.
REQ-006 stallreq_i  input  1  exe busy (mul/div in progress).
REQ-007 timer_irq_i  input  1  level-sensitive machine timer interrupt request.
REQ-008 csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i  input  32 each  current CSR values.
REQ-009 csr_we_o, csr_waddr_o, csr_wdata_o  output  1/12/32  CSR write port, registered.
REQ-010 hold_o  output  1  pipeline hold request, combinational from state.
REQ-011 int_assert_o, int_addr_o  output  1/32  one-cycle redirect pulse and redirect target, registered.

Function
REQ-012 States: IDLE, WAIT, W_MEPC, W_MCAUSE, W_MSTATUS, ASSERT, MRET_MSTATUS.
REQ-013 Sync trap: any of bits0-2 set in IDLE.
- Interrupt: timer_irq_i & mstatus.MIE (bit3) & mie.MTIE (bit7) in IDLE.
REQ-014 Priority on simultaneous events: sync trap > mret > timer; losing events are dropped.
- Timer stays pending because it is level-sensitive.
REQ-015 Sync trap and mret SHALL be accepted in IDLE immediately.
REQ-016 Timer accepted only when stallreq_i=0; otherwise IDLE->WAIT, holding there until stallreq_i=0, then ->W_MEPC.
- Trap/mret arriving during WAIT is ignored.
REQ-017 On acceptance, capture cause and return PC in internal registers.
- Sync trap return PC: inst_addr_i.
- Timer return PC: jump_addr_i if jump_enable_i, else inst_addr_i.
REQ-018 mcause values: ecall 11, ebreak 3, illegal 2, timer 0x8000_0007.
- Multiple sync bits resolve as illegal > ebreak > ecall.
REQ-019 Trap sequence, accept at cycle N:
- N+1 W_MEPC: write 0x341 = return PC.
- N+2 W_MCAUSE: write 0x342 = cause.
- N+3 W_MSTATUS: write 0x300 = mstatus with MPIE(bit7)=MIE, MIE=0, MPP(bits12:11)=2'b11.
- N+4 ASSERT: int_assert_o=1, int_addr_o = {mtvec[31:2],2'b00}.
- N+5 IDLE.
REQ-020 mret sequence, accept at cycle N:
- N+1 MRET_MSTATUS: write 0x300 = mstatus with MIE=MPIE, MPIE=1.
- N+2 ASSERT: int_assert_o=1, int_addr_o=mepc.
REQ-021 csr_we_o=1 exactly in write states; csr_waddr_o/csr_wdata_o=0 elsewhere; int_assert_o high exactly one cycle per accepted event.
REQ-022 hold_o=1 in every state except IDLE, and also in IDLE in the cycle an event is accepted or WAIT is entered.
REQ-023 No new event is accepted until the FSM has returned to IDLE.

Reset
REQ-024 On rst_i: state=IDLE; csr_we_o=0, csr_waddr_o=0, csr_wdata_o=0, int_assert_o=0, int_addr_o=0; captured PC/cause=0.
REQ-025 Reset mid-sequence abandons the sequence; partially written CSRs are not restored.

Structure
REQ-026 CSR addresses, mcause codes, exception bit positions and mstatus bit indices SHALL live in the shared defines file.
REQ-027 Single module with no sub-modules; the FSM state encoding is a localparam.

Verification
REQ-028 Ecall at PC 0x100, mtvec=0x200, MIE=1 -> writes mepc=0x100, mcause=11, mstatus MIE=0/MPIE=1 on N+1..N+3; int_assert at N+4 with addr 0x200.
REQ-029 Timer with MIE=1, MTIE=1, stallreq_i high 5 cycles -> hold_o during WAIT, no CSR write until stall drops, then mcause=0x8000_0007.
REQ-030 Timer with jump_enable_i=1, jump_addr_i=0x340 -> mepc written 0x340.
REQ-031 Ecall and timer in same cycle -> mcause=11; after mret restores MIE=1, timer taken next.
REQ-032 mret with mepc=0x104, MPIE=1 -> mstatus MIE=1/MPIE=1 at N+1; int_assert addr 0x104 at N+2.
REQ-033 rst_i asserted at W_MCAUSE -> outputs zero immediately, IDLE; next ecall runs the full sequence.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap controller: CSR addresses, mcause codes,
// exception flag positions, mstatus/mie bit indices, FSM encoding and the
// mstatus rewrite helpers used on trap entry and mret.
package trap_ctrl_pkg;

    // CSR addresses
    localparam logic [11:0] CsrMstatus = 12'h300;
    localparam logic [11:0] CsrMepc    = 12'h341;
    localparam logic [11:0] CsrMcause  = 12'h342;

    // mcause codes
    localparam logic [31:0] CauseEcall   = 32'd11;
    localparam logic [31:0] CauseEbreak  = 32'd3;
    localparam logic [31:0] CauseIllegal = 32'd2;
    localparam logic [31:0] CauseTimer   = 32'h8000_0007;

    // Exception flag bit positions in exception_i
    localparam int unsigned ExcEcall   = 0;
    localparam int unsigned ExcEbreak  = 1;
    localparam int unsigned ExcIllegal = 2;
    localparam int unsigned ExcMret    = 3;

    // mstatus / mie bit indices
    localparam int unsigned MstatusMie    = 3;
    localparam int unsigned MstatusMpie   = 7;
    localparam int unsigned MstatusMppLo  = 11;
    localparam int unsigned MstatusMppHi  = 12;
    localparam int unsigned MieMtie       = 7;

    // FSM state encoding
    localparam int unsigned StateWidth = 3;

    typedef enum logic [StateWidth-1:0] {
        StIdle        = 3'd0,
        StWait        = 3'd1,
        StWMepc       = 3'd2,
        StWMcause     = 3'd3,
        StWMstatus    = 3'd4,
        StAssert      = 3'd5,
        StMretMstatus = 3'd6
    } state_e;

    // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= machine.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] mstatus);
        logic [31:0] r;
        r = mstatus;
        r[MstatusMpie] = mstatus[MstatusMie];
        r[MstatusMie]  = 1'b0;
        r[MstatusMppHi:MstatusMppLo] = 2'b11;
        return r;
    endfunction

    // mret: MIE <= MPIE, MPIE <= 1.
    function automatic logic [31:0] mret_mstatus(input logic [31:0] mstatus);
        logic [31:0] r;
        r = mstatus;
        r[MstatusMie]  = mstatus[MstatusMpie];
        r[MstatusMpie] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller.
// Accepts synchronous exceptions (ecall/ebreak/illegal), mret and the machine
// timer interrupt, then sequences the CSR writes (mepc, mcause, mstatus) and
// issues a one-cycle redirect to mtvec or mepc.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   exception_i             exception flags from exe (ecall/ebreak/illegal/mret)
//   inst_addr_i             PC of the instruction in exe
//   jump_enable_i/addr_i    branch/jump resolved in exe and its target
//   stallreq_i              exe busy
//   timer_irq_i             level-sensitive timer interrupt
//   csr_*_i                 current mstatus, mie, mtvec, mepc
//   csr_we_o/waddr_o/wdata_o registered CSR write port
//   hold_o                  pipeline hold request
//   int_assert_o/int_addr_o registered one-cycle redirect pulse and target
module trap_ctrl
    import trap_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] exception_i,
    input  logic [31:0] inst_addr_i,
    input  logic        jump_enable_i,
    input  logic [31:0] jump_addr_i,
    input  logic        stallreq_i,
    input  logic        timer_irq_i,
    input  logic [31:0] csr_mstatus_i,
    input  logic [31:0] csr_mie_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    output logic        csr_we_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        hold_o,
    output logic        int_assert_o,
    output logic [31:0] int_addr_o
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cause_q, cause_d;

    logic        csr_we_d;
    logic [11:0] csr_waddr_d;
    logic [31:0] csr_wdata_d;
    logic        int_assert_d;
    logic [31:0] int_addr_d;

    logic        sync_trap, is_mret, timer_ok;
    logic [31:0] sync_cause, timer_pc;
    logic        unused_bits;

    assign sync_trap = exception_i[ExcEcall] | exception_i[ExcEbreak] | exception_i[ExcIllegal];
    assign is_mret   = exception_i[ExcMret];
    assign timer_ok  = timer_irq_i & csr_mstatus_i[MstatusMie] & csr_mie_i[MieMtie];
    assign timer_pc  = jump_enable_i ? jump_addr_i : inst_addr_i;
    assign unused_bits = ^{exception_i[31:4], csr_mtvec_i[1:0], csr_mie_i};

    always_comb begin
        if (exception_i[ExcIllegal]) begin
            sync_cause = CauseIllegal;
        end else if (exception_i[ExcEbreak]) begin
            sync_cause = CauseEbreak;
        end else begin
            sync_cause = CauseEcall;
        end
    end

    // Next state, capture and hold
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cause_d = cause_q;
        hold_o  = (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                if (sync_trap) begin
                    state_d = StWMepc;
                    pc_d    = inst_addr_i;
                    cause_d = sync_cause;
                    hold_o  = 1'b1;
                end else if (is_mret) begin
                    state_d = StMretMstatus;
                    hold_o  = 1'b1;
                end else if (timer_ok) begin
                    hold_o = 1'b1;
                    if (stallreq_i) begin
                        state_d = StWait;
                    end else begin
                        state_d = StWMepc;
                        pc_d    = timer_pc;
                        cause_d = CauseTimer;
                    end
                end
            end
            // Only a pending timer can get here; trap/mret flags are ignored.
            StWait: begin
                if (!stallreq_i) begin
                    state_d = StWMepc;
                    pc_d    = timer_pc;
                    cause_d = CauseTimer;
                end
            end
            StWMepc:       state_d = StWMcause;
            StWMcause:     state_d = StWMstatus;
            StWMstatus:    state_d = StAssert;
            StMretMstatus: state_d = StAssert;
            StAssert:      state_d = StIdle;
            default:       state_d = StIdle;
        endcase
    end

    // Outputs are registered, so decode them from the state being entered.
    always_comb begin
        csr_we_d     = 1'b0;
        csr_waddr_d  = 12'h000;
        csr_wdata_d  = 32'h0;
        int_assert_d = 1'b0;
        int_addr_d   = 32'h0;
        unique case (state_d)
            StWMepc: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = CsrMepc;
                csr_wdata_d = pc_d;
            end
            StWMcause: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = CsrMcause;
                csr_wdata_d = cause_q;
            end
            StWMstatus: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = CsrMstatus;
                csr_wdata_d = trap_mstatus(csr_mstatus_i);
            end
            StMretMstatus: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = CsrMstatus;
                csr_wdata_d = mret_mstatus(csr_mstatus_i);
            end
            StAssert: begin
                int_assert_d = 1'b1;
                int_addr_d   = (state_q == StMretMstatus) ? csr_mepc_i
                                                          : {csr_mtvec_i[31:2], 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            pc_q         <= 32'h0;
            cause_q      <= 32'h0;
            csr_we_o     <= 1'b0;
            csr_waddr_o  <= 12'h000;
            csr_wdata_o  <= 32'h0;
            int_assert_o <= 1'b0;
            int_addr_o   <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            cause_q      <= cause_d;
            csr_we_o     <= csr_we_d;
            csr_waddr_o  <= csr_waddr_d;
            csr_wdata_o  <= csr_wdata_d;
            int_assert_o <= int_assert_d;
            int_addr_o   <= int_addr_d;
        end
    end

endmodule
